// File: rtl/ice51_uart_pkg.sv
// ice51_uart_pkg: shared constants, state encodings and sizing helper for the ice51 UART loader.
package ice51_uart_pkg;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;
    localparam int BYTES_PER_WORD_DEFAULT = 1;

    typedef enum logic [2:0] {IDLE, LEN_HI, DATA, CSUM, ACK_TX, RUN} ldr_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE} rx_state_e;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/ice51_uart_rx.sv
// ice51_uart_rx: 8N1 receiver with input synchroniser and start-glitch rejection;
// emits one-cycle byte-valid or framing-error pulses one cycle after the stop sample.
module ice51_uart_rx
    import ice51_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          stop_q, stop_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            stop_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        stop_d  = stop_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RX_START;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (cnt_q == FULL) begin
                cnt_d = '0;
                sh_d  = {rx_s, sh_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = RX_STOP;
            end
            RX_STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                stop_d  = rx_s;
                state_d = RX_DONE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o      = sh_q;
    assign valid_o     = (state_q == RX_DONE) && stop_q;
    assign frame_err_o = (state_q == RX_DONE) && !stop_q;
endmodule

// File: rtl/ice51_uart_loader.sv
// ice51_uart_loader: loads a length-prefixed, checksummed image from UART into code memory,
// holding the CPU in reset until the image is accepted and replying ACK or NAK.
module ice51_uart_loader
    import ice51_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int PRELOAD      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    output logic              o_uart_tx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_err,
    input  logic              i_reload
);
    localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TCW = $clog2(CLKS_PER_BIT);
    localparam logic [7:0] LAST_BYTE = 8'(BYTES_PER_WORD - 1);
    localparam logic [TCW-1:0] TX_FULL = TCW'(CLKS_PER_BIT - 1);

    ldr_state_e        state_q, state_d;
    logic [15:0]       len_q, len_d, n;
    logic [16:0]       words_q, words_d;
    logic [7:0]        bidx_q, bidx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d, wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic [9:0]        txsh_q, txsh_d;
    logic [TCW-1:0]    txcnt_q, txcnt_d;
    logic [3:0]        txbit_q, txbit_d;
    logic              cpu_rst_q;
    logic              tx_load, tx_ack;
    logic [7:0]        rx_byte;
    logic              rx_valid, rx_err;

    ice51_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .rx_i        (i_uart_rx),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_err)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= (PRELOAD != 0) ? RUN : IDLE;
            len_q     <= '0;
            words_q   <= '0;
            bidx_q    <= '0;
            addr_q    <= '0;
            wbuf_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            sum_q     <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            txsh_q    <= '1;
            txcnt_q   <= '0;
            txbit_q   <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            words_q   <= words_d;
            bidx_q    <= bidx_d;
            addr_q    <= addr_d;
            wbuf_q    <= wbuf_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            sum_q     <= sum_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            txsh_q    <= txsh_d;
            txcnt_q   <= txcnt_d;
            txbit_q   <= txbit_d;
            cpu_rst_q <= (state_d != RUN);
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        n       = {rx_byte, len_q[7:0]};
        words_d = words_q;
        bidx_d  = bidx_q;
        // The address steps after each write pulse, but never past the final word.
        addr_d  = (we_q && state_q == DATA) ? addr_q + 1'b1 : addr_q;
        wbuf_d  = wbuf_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        sum_d   = sum_q;
        err_d   = err_q;
        ack_d   = ack_q;
        txsh_d  = txsh_q;
        txcnt_d = txcnt_q;
        txbit_d = txbit_q;
        tx_load = 1'b0;
        tx_ack  = 1'b0;
        if (rx_err && state_q inside {IDLE, LEN_HI, DATA, CSUM}) begin
            err_d   = 1'b1;
            tx_load = 1'b1;
        end
        case (state_q)
            IDLE: if (rx_valid) begin
                len_d   = {8'h00, rx_byte};
                err_d   = 1'b0;
                sum_d   = '0;
                state_d = LEN_HI;
            end
            LEN_HI: if (rx_valid) begin
                len_d = n;
                if ({16'h0, n} > 32'(DEPTH)) begin
                    err_d   = 1'b1;
                    tx_load = 1'b1;
                end else if (n == 16'd0) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                    addr_d  = '0;
                    words_d = '0;
                    bidx_d  = '0;
                end
            end
            DATA: if (rx_valid) begin
                sum_d  = sum_q + rx_byte;
                wbuf_d = (wbuf_q >> 8) | (DATA_W'(rx_byte) << (DATA_W - 8));
                bidx_d = (bidx_q == LAST_BYTE) ? 8'd0 : bidx_q + 8'd1;
                if (bidx_q == LAST_BYTE) begin
                    we_d    = 1'b1;
                    wdata_d = wbuf_d;
                    words_d = words_q + 17'd1;
                    if (words_q + 17'd1 == {1'b0, len_q}) state_d = CSUM;
                end
            end
            CSUM: if (rx_valid) begin
                tx_load = 1'b1;
                tx_ack  = (rx_byte == sum_q);
                err_d   = !tx_ack;
            end
            ACK_TX: if (txcnt_q == TX_FULL) begin
                txcnt_d = '0;
                txsh_d  = {1'b1, txsh_q[9:1]};
                txbit_d = txbit_q + 4'd1;
                if (txbit_q == 4'd9) state_d = ack_q ? RUN : IDLE;
            end else begin
                txcnt_d = txcnt_q + 1'b1;
            end
            RUN: if (i_reload) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tx_load) begin
            state_d = ACK_TX;
            ack_d   = tx_ack;
            txsh_d  = {1'b1, tx_ack ? ACK : NAK, 1'b0};
            txcnt_d = '0;
            txbit_d = '0;
        end
    end

    assign o_uart_tx   = txsh_q[0];
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_cpu_rst   = cpu_rst_q;
    assign o_busy      = state_q inside {LEN_HI, DATA, CSUM, ACK_TX};
    assign o_err       = err_q;
endmodule
